// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: 4-digit multiplexed 7-segment scanner with blanking gaps and frame-synchronous value update.
module display_scan_scheduler #(
  parameter int CLK_DIV = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);
  typedef enum logic {SHOW, BLANK} state_t;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] digit, digit_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0] active, pending;
  logic flag, show_end, blank_end, xfer, lit;
  logic [3:0] nib;
  logic [6:0] dec;
  always_comb begin
    show_end = state == SHOW && cnt == SHOW_LAST;
    blank_end = state == BLANK && cnt == BLANK_LAST;
    state_n = state;
    cnt_n = cnt + 1'b1;
    digit_n = digit;
    if (show_end) begin
      cnt_n = '0;
      if (BLANK_CYCLES > 0) state_n = BLANK;
      else digit_n = digit + 1'b1;
    end
    if (blank_end) begin
      cnt_n = '0;
      state_n = SHOW;
      digit_n = digit + 1'b1;
    end
    frame_done = digit == 2'd3 && (BLANK_CYCLES > 0 ? blank_end : show_end);
    data_ready = !flag;
    xfer = data_valid && !flag;
    nib = active[{digit, 2'b00} +: 4];
    lit = state == SHOW && digit_en[digit];
  end
  always_comb begin
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  end
  // A word accepted on the boundary cycle lands in pending and waits a full frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SHOW;
      digit <= '0;
      cnt <= '0;
      active <= '0;
      pending <= '0;
      flag <= 1'b0;
      seg <= 7'h7F;
      an <= 4'hF;
    end else begin
      state <= state_n;
      digit <= digit_n;
      cnt <= cnt_n;
      seg <= lit ? dec : 7'h7F;
      an <= lit ? ~(4'b0001 << digit) : 4'hF;
      if (xfer) begin
        pending <= data_in;
        flag <= 1'b1;
      end else if (frame_done) flag <= 1'b0;
      if (frame_done && flag) active <= pending;
    end
  end
endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb_display_scan_scheduler: checks a blanking instance and a no-blanking instance against a cycle-index model.
module tb_display_scan_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] data_in;
  logic data_valid;
  logic [3:0] digit_en;
  logic [6:0] seg_o [2];
  logic [3:0] an_o [2];
  logic ready_o [2];
  logic fd_o [2];
  int tests = 0;
  int fails = 0;
  int k [2];
  logic [15:0] act [2];
  logic [15:0] pend [2];
  logic flg [2];
  logic [6:0] eseg [2];
  logic [3:0] ean [2];

  always #5 clk = ~clk;

  display_scan_scheduler #(.CLK_DIV(4), .BLANK_CYCLES(2), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(ready_o[0]),
    .digit_en(digit_en), .seg(seg_o[0]), .an(an_o[0]), .frame_done(fd_o[0]));
  display_scan_scheduler #(.CLK_DIV(4), .BLANK_CYCLES(0), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(ready_o[1]),
    .digit_en(digit_en), .seg(seg_o[1]), .an(an_o[1]), .frame_done(fd_o[1]));

  function automatic int slot(int i);
    return 4 + (i == 0 ? 2 : 0);
  endfunction
  function automatic int pos(int i, int kk);
    return kk % (4 * slot(i));
  endfunction
  function automatic int dig(int i, int kk);
    return pos(i, kk) / slot(i);
  endfunction
  function automatic logic bnd(int i, int kk);
    return pos(i, kk) == 4 * slot(i) - 1;
  endfunction
  function automatic logic lit(int i, int kk, logic [3:0] en);
    return (pos(i, kk) % slot(i) < 4) && en[dig(i, kk)];
  endfunction
  function automatic logic [6:0] hex7(logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // k counts clock edges since reset release; position in the frame follows from it directly.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        k[i] <= 0;
        act[i] <= '0;
        pend[i] <= '0;
        flg[i] <= 1'b0;
        eseg[i] <= 7'h7F;
        ean[i] <= 4'hF;
      end else begin
        eseg[i] <= lit(i, k[i], digit_en) ? hex7(4'(act[i] >> (4 * dig(i, k[i])))) : 7'h7F;
        ean[i] <= lit(i, k[i], digit_en) ? ~(4'b0001 << dig(i, k[i])) : 4'hF;
        if (data_valid && !flg[i]) begin
          pend[i] <= data_in;
          flg[i] <= 1'b1;
        end else if (bnd(i, k[i])) flg[i] <= 1'b0;
        if (bnd(i, k[i]) && flg[i]) act[i] <= pend[i];
        k[i] <= k[i] + 1;
      end
    end
  end

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("seg%0d", i), 16'(seg_o[i]), 16'(eseg[i]));
      chk($sformatf("an%0d", i), 16'(an_o[i]), 16'(ean[i]));
      chk($sformatf("frame_done%0d", i), 16'(fd_o[i]), 16'(!rst && bnd(i, k[i])));
      chk($sformatf("ready%0d", i), 16'(ready_o[i]), 16'(!flg[i]));
    end
  end

  task automatic go_to(int t);
    while (k[0] < t) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    data_valid = 1'b0;
    data_in = '0;
    digit_en = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rel_an", 16'(an_o[0]), 16'hF);
    chk("rel_seg", 16'(seg_o[0]), 16'h7F);
    chk("rel_ready", 16'(ready_o[0]), 16'h1);
    go_to(1);
    chk("d0_an", 16'(an_o[0]), 16'hE);
    chk("d0_seg", 16'(seg_o[0]), 16'h40);
    chk("nb_d0_an", 16'(an_o[1]), 16'hE);
    go_to(5);
    chk("blank_an", 16'(an_o[0]), 16'hF);
    chk("blank_seg", 16'(seg_o[0]), 16'h7F);
    chk("nb_d1_an", 16'(an_o[1]), 16'hD);
    go_to(7);
    chk("d1_an", 16'(an_o[0]), 16'hD);
    go_to(15);
    chk("nb_frame", 16'(fd_o[1]), 16'h1);
    go_to(23);
    chk("frame0", 16'(fd_o[0]), 16'h1);
    go_to(30);
    data_in = 16'h3A0F;
    data_valid = 1'b1;
    go_to(31);
    chk("ready_low", 16'(ready_o[0]), 16'h0);
    data_valid = 1'b0;
    go_to(47);
    chk("frame1", 16'(fd_o[0]), 16'h1);
    chk("ready_still_low", 16'(ready_o[0]), 16'h0);
    go_to(48);
    chk("ready_back", 16'(ready_o[0]), 16'h1);
    go_to(49);
    chk("new_d0_seg", 16'(seg_o[0]), 16'h0E);
    go_to(55);
    chk("new_d1_seg", 16'(seg_o[0]), 16'h40);
    go_to(61);
    chk("new_d2_seg", 16'(seg_o[0]), 16'h08);
    go_to(67);
    chk("new_d3_seg", 16'(seg_o[0]), 16'h30);
    chk("new_d3_an", 16'(an_o[0]), 16'h7);
    go_to(71);
    chk("frame2", 16'(fd_o[0]), 16'h1);
    data_in = 16'h1234;
    data_valid = 1'b1;
    go_to(72);
    chk("bnd_xfer_ready", 16'(ready_o[0]), 16'h0);
    data_valid = 1'b0;
    go_to(73);
    chk("bnd_xfer_old", 16'(seg_o[0]), 16'h0E);
    go_to(96);
    digit_en = 4'b0101;
    go_to(97);
    chk("en_d0_seg", 16'(seg_o[0]), 16'h19);
    chk("en_d0_an", 16'(an_o[0]), 16'hE);
    go_to(103);
    chk("en_d1_an", 16'(an_o[0]), 16'hF);
    chk("en_d1_seg", 16'(seg_o[0]), 16'h7F);
    go_to(109);
    chk("en_d2_seg", 16'(seg_o[0]), 16'h24);
    chk("en_d2_an", 16'(an_o[0]), 16'hB);
    go_to(120);
    digit_en = 4'hF;
    data_in = 16'hAAAA;
    data_valid = 1'b1;
    for (int t = 121; t < 144; t++) begin
      go_to(t);
      data_in = 16'($urandom);
    end
    go_to(144);
    chk("hold_ready", 16'(ready_o[0]), 16'h1);
    data_in = 16'hCCCC;
    go_to(145);
    data_valid = 1'b0;
    chk("hold_seg", 16'(seg_o[0]), 16'h08);
    chk("hold_accept", 16'(ready_o[0]), 16'h0);
    go_to(169);
    chk("hold_next_seg", 16'(seg_o[0]), 16'h46);
    repeat (1500) begin
      @(negedge clk);
      digit_en = 4'($urandom);
      data_valid = 1'($urandom_range(0, 1));
      data_in = 16'($urandom);
    end
    digit_en = 4'hF;
    data_in = 16'h8888;
    data_valid = 1'b1;
    n = 0;
    while (!(flg[0] && pos(0, k[0]) == 16) && n < 300) begin
      @(negedge clk);
      if (flg[0]) data_valid = 1'b0;
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL rst_setup: timeout got %0d expected <300", n);
    end
    data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 16'(an_o[0]), 16'hF);
    chk("arst_seg", 16'(seg_o[0]), 16'h7F);
    chk("arst_ready", 16'(ready_o[0]), 16'h1);
    @(negedge clk);
    rst = 1'b0;
    go_to(1);
    chk("post_rst_seg", 16'(seg_o[0]), 16'h40);
    chk("post_rst_ready", 16'(ready_o[0]), 16'h1);
    go_to(30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
